// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words,
// writes them to sequential IM addresses and holds the core in reset while loading.
module im_loader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     num_q, num_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic [ADDR_W:0]     num_sat;

    assign num_sat = (num_words > MaxWords) ? MaxWords : num_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            num_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        count_d = count_q;
        idx_d   = idx_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        csum_d  = csum_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    num_d   = num_sat;
                    count_d = '0;
                    idx_d   = '0;
                    waddr_d = '0;
                    csum_d  = '0;
                    state_d = (num_sat == '0) ? StDone : StRecv;
                end
            end
            StRecv: begin
                if (byte_valid) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = byte_in;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                csum_d  = csum_q ^ wdata_q;
                count_d = count_q + 1'b1;
                // Address wraps naturally; only a full-depth load reaches it, and that ends here.
                waddr_d = waddr_q + 1'b1;
                idx_d   = '0;
                state_d = (count_q + 1'b1 == num_q) ? StDone : StRecv;
            end
            default: state_d = StIdle;
        endcase
    end

    assign byte_ready = (state_q == StRecv);
    assign im_we      = (state_q == StWrite);
    assign cpu_hold   = (state_q == StRecv) || (state_q == StWrite);
    assign done       = (state_q == StDone);
    assign im_waddr   = waddr_q;
    assign im_wdata   = wdata_q;
    assign checksum   = csum_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomized self-checking bench for im_loader against a word-list reference model.
module tb_im_loader;

    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          done;
    logic [31:0]   checksum;

    im_loader #(
        .ADDR_W (AW),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Observed IM writes, captured mid-cycle.
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            ready_in_write = 0;

    always @(negedge clk) begin
        if (rst_n && im_we) begin
            wr_addr.push_back(im_waddr);
            wr_data.push_back(im_wdata);
            if (byte_ready) ready_in_write++;
        end
    end

    logic [31:0] img [DEPTH];

    // mode: 0 valid always high, 1 valid toggles each cycle, 2 random valid plus stray starts.
    // abort_at >= 0 pulses reset once that many bytes have been accepted.
    task automatic run_load(input int n_req, input int mode, input int abort_at, input bit chk_lat);
        int          n_exp;
        logic [7:0]  bytes[$];
        logic [31:0] exp_sum;
        int          lat;
        int          accepted;
        bit          pend;
        bit          got_done;
        bit          aborted;
        n_exp    = (n_req > DEPTH) ? DEPTH : n_req;
        exp_sum  = '0;
        lat      = 0;
        accepted = 0;
        pend     = 0;
        got_done = 0;
        aborted  = 0;
        for (int i = 0; i < n_exp; i++) begin
            for (int k = 0; k < 4; k++) bytes.push_back(8'(img[i] >> (8 * k)));
            exp_sum ^= img[i];
        end
        wr_addr.delete();
        wr_data.delete();
        ready_in_write = 0;

        @(negedge clk);
        start      = 1'b1;
        num_words  = (AW + 1)'(n_req);
        byte_valid = 1'b0;
        while (lat < 3000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start     = 1'b0;
                num_words = (AW + 1)'($urandom);
                check("hold_rise", 32'(cpu_hold), 32'(n_exp > 0));
            end
            if (pend) begin
                void'(bytes.pop_front());
                accepted++;
                pend = 0;
            end
            if (abort_at >= 0 && accepted == abort_at) begin
                aborted    = 1;
                byte_valid = 1'b0;
                start      = 1'b0;
                rst_n      = 1'b0;
                #1;
                check("abort_hold", 32'(cpu_hold), 0);
                check("abort_ready", 32'(byte_ready), 0);
                check("abort_done", 32'(done), 0);
                check("abort_waddr", 32'(im_waddr), 0);
                rst_n = 1'b1;
                break;
            end
            if (done) begin
                got_done = 1;
                break;
            end
            start = (mode == 2) && ($urandom_range(0, 5) == 0);
            if (start) num_words = (AW + 1)'($urandom);
            if (bytes.size() > 0 &&
                (mode == 0 || (mode == 1 && lat[0]) || (mode == 2 && $urandom_range(0, 1) == 1)))
            begin
                byte_valid = 1'b1;
                byte_in    = bytes[0];
            end else begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
            end
            pend = byte_valid && byte_ready;
        end
        start      = 1'b0;
        byte_valid = 1'b0;

        if (aborted) begin
            check("abort_nwrites", 32'(wr_addr.size()), 1);
            if (wr_addr.size() > 0) begin
                check("abort_addr0", 32'(wr_addr[0]), 0);
                check("abort_data0", wr_data[0], img[0]);
            end
        end else begin
            check("done_seen", 32'(got_done), 1);
            if (chk_lat) check("done_lat", 32'(lat), (n_exp == 0) ? 1 : 5 * n_exp + 1);
            check("hold_fall", 32'(cpu_hold), 0);
            check("ready_done", 32'(byte_ready), 0);
            check("nwrites", 32'(wr_addr.size()), 32'(n_exp));
            for (int i = 0; i < wr_addr.size() && i < n_exp; i++) begin
                check($sformatf("addr[%0d]", i), 32'(wr_addr[i]), 32'(i % DEPTH));
                check($sformatf("data[%0d]", i), wr_data[i], img[i]);
            end
            check("checksum", checksum, exp_sum);
            check("waddr_end", 32'(im_waddr), 32'(n_exp % DEPTH));
            check("ready_in_write", 32'(ready_in_write), 0);
            check("bytes_left", 32'(bytes.size()), 0);
        end
    endtask

    initial begin
        int seen_ready;
        int seen_hold;
        int seen_done;
        int n_rand;
        int mode;

        repeat (2) @(negedge clk);
        check("rst_waddr", 32'(im_waddr), 0);
        check("rst_wdata", im_wdata, 0);
        check("rst_checksum", checksum, 0);
        check("rst_flags", {28'd0, byte_ready, im_we, cpu_hold, done}, 0);
        rst_n = 1'b1;

        // Valid bytes with no start must be ignored.
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        seen_ready = 0;
        seen_hold  = 0;
        seen_done  = 0;
        wr_addr.delete();
        repeat (12) begin
            @(negedge clk);
            seen_ready += int'(byte_ready);
            seen_hold  += int'(cpu_hold);
            seen_done  += int'(done);
        end
        byte_valid = 1'b0;
        check("idle_ready", 32'(seen_ready), 0);
        check("idle_writes", 32'(wr_addr.size()), 0);
        check("idle_hold", 32'(seen_hold), 0);
        check("idle_done", 32'(seen_done), 0);

        img[0] = 32'h0000_0013;
        img[1] = 32'h00A0_02B3;
        run_load(2, 0, -1, 1);
        check("known_checksum", checksum, 32'h00A0_02A0);
        run_load(2, 1, -1, 0);
        run_load(0, 0, -1, 1);

        for (int i = 0; i < DEPTH; i++) img[i] = i;
        run_load(DEPTH, 0, -1, 1);
        run_load(40, 0, -1, 1);

        img[0] = 32'h0000_0013;
        img[1] = 32'h00A0_02B3;
        run_load(2, 0, 6, 0);
        run_load(2, 0, -1, 1);

        for (int r = 0; r < 8; r++) begin
            n_rand = $urandom_range(0, 40);
            mode   = $urandom_range(0, 2);
            for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
            run_load(n_rand, mode, -1, mode == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction memory: fills the IM contents at run time from a byte stream before the single-cycle core starts fetching.
- Assembles little-endian bytes into 32-bit instruction words and drives the IM write port with sequential word addresses.
- Holds the core in reset while a load is in progress.
- Keeps a running XOR checksum so the host side can confirm the image.

Parameters:
- ADDR_W, 5, IM word-address width; IM depth is 2**ADDR_W words.
- DATA_W, 32, instruction word width; must be 32, which is 4 bytes per word.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- num_words  input  ADDR_W+1  number of words to load; sampled on the accepted start; legal range 0..2**ADDR_W.
- byte_in  input  8  incoming byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- im_we  output  1  IM write enable, one-cycle pulse per word.
- im_waddr  output  ADDR_W  IM word write address.
- im_wdata  output  32  IM write data.
- cpu_hold  output  1  high while loading; holds the core in reset.
- done  output  1  high from load completion until the next accepted start.
- checksum  output  32  XOR of all words written in the current or last load.

Behaviour:
- Reset (async, rst_n=0) sets: state=IDLE; byte_ready=0; im_we=0; im_waddr=0; im_wdata=0; cpu_hold=0; done=0; checksum=0; byte index=0; word count=0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE / DONE with start=1:
  - Latch num_words; clear checksum, im_waddr, byte index and done.
  - Set cpu_hold=1.
  - If num_words=0, go to DONE next cycle with cpu_hold=0 and done=1.
  - Otherwise go to RECV.
- Saturation: num_words > 2**ADDR_W is saturated to 2**ADDR_W.
- RECV:
  - byte_ready=1.
  - A byte is accepted on the cycle where byte_valid and byte_ready are both 1.
  - Byte k (k=0..3) goes to im_wdata[8k+7:8k]; byte 0 is the LSB.
  - On acceptance of byte 3, go to WRITE.
  - With byte_valid=0, stay in RECV indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0, im_we=1.
  - im_waddr and im_wdata are stable for the whole cycle.
  - checksum updates to checksum XOR im_wdata at the end of the cycle.
  - Next cycle: word count +1, im_waddr +1, byte index=0.
  - If word count = num_words, go to DONE; otherwise go to RECV.
- Address wrap: im_waddr wraps modulo 2**ADDR_W. It only reaches the wrap when num_words=2**ADDR_W, and the load finishes on that final write.
- DONE: cpu_hold=0; done=1; byte_ready=0; im_we=0. im_waddr and checksum hold their values.
- Throughput: 5 cycles per word with byte_valid held high (4 accepts + 1 write).
- Latency:
  - cpu_hold rises the cycle after start is accepted.
  - cpu_hold falls on the same edge that done rises.
- start while in RECV or WRITE is ignored; it never corrupts a load in progress.
- Bytes presented while byte_ready=0 are not consumed; the source must hold them.
- rst_n asserted mid-load:
  - Immediate return to IDLE.
  - Any partially assembled word is discarded and never written.
  - cpu_hold drops.
  - Words already written remain in IM.

Test Plan:
- Reset then idle: drive byte_valid=1 with no start -> byte_ready stays 0, im_we never pulses, cpu_hold=0, done=0.
- start, num_words=2, bytes 13,00,00,00,B3,02,A0,00 with valid held high:
  - im_we pulses twice: addr0 = 0x00000013, addr1 = 0x00A002B3.
  - done=1 on cycle 11 after start; checksum = 0x00A002A0.
- Same image with byte_valid toggling 1/0 every cycle -> identical writes and checksum; no byte lost or duplicated; byte_ready=0 during both WRITE cycles.
- num_words=0 -> done=1 one cycle after start; no im_we pulse; checksum=0.
- num_words=32 with word i = i -> 32 writes at addr 0..31; im_waddr wraps to 0 in DONE; checksum = 0x00000000.
- Mid-load reset: rst_n pulsed low after 6 bytes of a 2-word load -> exactly one write occurred (addr0); cpu_hold=0; state IDLE; a new start then loads from addr0.
